// File: rtl/eth_tx_mac.sv
// eth_tx_mac -- GMII-side Ethernet transmit framer (MAC byte clock domain).
//
// Takes a payload byte stream on a valid/ready/last handshake and sends it
// as a GMII frame: 7x 0x55 preamble, 0xD5 SFD, payload, optional zero pad
// up to MIN_FRAME bytes, and a 4-byte CRC-32 FCS (LSB first). It then holds
// tx_en low for IFG_BYTES cycles before the next frame may start.
// If input starves mid-payload, one error byte (tx_en=1, tx_er=1) is sent,
// underflow pulses, and the rest of that frame is drained from the input.
//
// Build option: define ETH_TX_PAD_EN to zero-pad short frames to MIN_FRAME.
//
// Ports:
//   clk, rst        MAC byte clock, asynchronous active-high reset
//   s_data/s_valid/s_last/s_ready   payload stream (transfer = valid&&ready)
//   gmii_txd/gmii_tx_en/gmii_tx_er  registered GMII transmit outputs
//   busy            FSM not in IDLE
//   underflow       registered one-cycle pulse on starvation abort
module eth_tx_mac #(
    parameter int IFG_BYTES = 12,
    parameter int MIN_FRAME = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       underflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_FCS, S_DRAIN, S_IFG
`ifdef ETH_TX_PAD_EN
        , S_PAD
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;      // preamble / FCS / IFG cycle counter
    logic [15:0] len_q, len_d;      // payload+pad byte count, saturating
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d, er_q, er_d, uf_q, uf_d;
    logic [31:0] fcs;

    // Reflected CRC-32 (0xEDB88320), one byte per cycle, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign s_ready    = (state_q == S_DATA) || (state_q == S_DRAIN);
    assign busy       = (state_q != S_IDLE);
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = en_q;
    assign gmii_tx_er = er_q;
    assign underflow  = uf_q;
    assign fcs        = ~crc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        crc_d   = crc_q;
        txd_d   = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
        uf_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    state_d = S_PRE;
                    cnt_d   = 16'd0;
                end
            end
            S_PRE: begin
                en_d  = 1'b1;
                txd_d = 8'h55;
                crc_d = 32'hFFFF_FFFF;
                len_d = 16'd0;
                if (cnt_q == 16'd6) begin
                    state_d = S_SFD;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SFD: begin
                en_d    = 1'b1;
                txd_d   = 8'hD5;
                state_d = S_DATA;
            end
            S_DATA: begin
                en_d = 1'b1;
                if (s_valid) begin
                    txd_d = s_data;
                    crc_d = crc_next(crc_q, s_data);
                    len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                    if (s_last) begin
                        cnt_d   = 16'd0;
                        state_d = S_FCS;
`ifdef ETH_TX_PAD_EN
                        if ((32'(len_q) + 32'd1) < 32'(MIN_FRAME))
                            state_d = S_PAD;
`endif
                    end
                end else begin
                    // Starved mid-frame: poison the frame and drop the rest.
                    er_d    = 1'b1;
                    uf_d    = 1'b1;
                    state_d = S_DRAIN;
                end
            end
`ifdef ETH_TX_PAD_EN
            S_PAD: begin
                en_d  = 1'b1;
                crc_d = crc_next(crc_q, 8'h00);
                len_d = len_q + 16'd1;
                if ((32'(len_q) + 32'd1) >= 32'(MIN_FRAME)) begin
                    state_d = S_FCS;
                    cnt_d   = 16'd0;
                end
            end
`endif
            S_FCS: begin
                en_d = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    txd_d = fcs[7:0];
                    2'd1:    txd_d = fcs[15:8];
                    2'd2:    txd_d = fcs[23:16];
                    default: txd_d = fcs[31:24];
                endcase
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = S_IFG;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                if (s_valid && s_last) begin
                    state_d = S_IFG;
                    cnt_d   = 16'd0;
                end
            end
            S_IFG: begin
                // Leaving on the last gap cycle gives exactly IFG_BYTES idles.
                if (cnt_q == 16'(IFG_BYTES - 1)) begin
                    state_d = s_valid ? S_PRE : S_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            len_q   <= 16'd0;
            crc_q   <= 32'hFFFF_FFFF;
            txd_q   <= 8'h00;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            en_q    <= en_d;
            er_q    <= er_d;
            uf_q    <= uf_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_mac.sv
module tb_eth_tx_mac;
    localparam int IFG   = 12;
    localparam int MINF  = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, s_last;
    logic       s_ready;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, busy, underflow;

    eth_tx_mac #(.IFG_BYTES(IFG), .MIN_FRAME(MINF)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er), .busy(busy), .underflow(underflow)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- wire monitor: splits tx_en bursts into frames
    logic [7:0] fr_bytes[$];
    int         fr_len[$], fr_er[$], fr_gap[$];
    int         cur_len = 0, cur_er = 0, cur_gap = 0, gap_cnt = 1000;
    int         uf_cnt = 0, er_outside = 0, first_en_cyc = 0;
    bit         prev_en = 1'b0;

    always @(negedge clk) begin
        if (underflow === 1'b1) uf_cnt++;
        if (gmii_tx_en === 1'b1) begin
            if (!prev_en) begin
                cur_gap = gap_cnt; cur_len = 0; cur_er = 0; first_en_cyc = cyc;
            end
            fr_bytes.push_back(gmii_txd);
            cur_len++;
            if (gmii_tx_er === 1'b1) cur_er++;
            prev_en = 1'b1;
        end else begin
            if (gmii_tx_er === 1'b1) er_outside++;
            if (prev_en) begin
                fr_len.push_back(cur_len); fr_er.push_back(cur_er); fr_gap.push_back(cur_gap);
                gap_cnt = 1;
            end else begin
                gap_cnt++;
            end
            prev_en = 1'b0;
        end
    end

    // ---------------- reference model
    int unsigned crc_tab[256];
    logic [7:0]  pay[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          got_er, got_gap;
    int          first_wait, stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int unsigned crc_upd(input int unsigned c, input logic [7:0] b);
        return (c >> 8) ^ crc_tab[(c ^ 32'(b)) & 32'hFF];
    endfunction

    // Full expected wire image of a well-formed frame carrying pay.
    task automatic build_exp();
        int unsigned c;
        int unsigned f;
        exp_q = {};
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFF_FFFF;
        foreach (pay[i]) begin exp_q.push_back(pay[i]); c = crc_upd(c, pay[i]); end
`ifdef ETH_TX_PAD_EN
        for (int i = pay.size(); i < MINF; i++) begin exp_q.push_back(8'h00); c = crc_upd(c, 8'h00); end
`endif
        f = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
    endtask

    task automatic rand_pay(input int n);
        pay = {};
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    // ---------------- stimulus helpers
    task automatic push_byte(input logic [7:0] d, input logic last, output int waits);
        logic r;
        waits = 0;
        s_valid = 1'b1; s_data = d; s_last = last;
        forever begin
            @(negedge clk); r = s_ready;
            @(posedge clk); #1;
            if (r) break;
            waits++;
            if (waits > 4000) begin chk("push_timeout", 32'(waits), 32'd0); break; end
        end
    endtask

    task automatic send_range(input int lo, input int hi, input bit drop);
        int w;
        for (int i = lo; i < hi; i++) begin
            push_byte(pay[i], (i == pay.size() - 1), w);
            if (i == lo) first_wait = w; else stall += w;
        end
        if (drop) begin s_valid = 1'b0; s_last = 1'b0; end
    endtask

    task automatic get_frame(input string tag);
        int n = 0;
        int l;
        while (fr_len.size() == 0 && n < 5000) begin @(posedge clk); n++; end
        chk({tag, "_present"}, 32'(fr_len.size() > 0), 32'd1);
        got_q = {};
        if (fr_len.size() > 0) begin
            l = fr_len.pop_front(); got_er = fr_er.pop_front(); got_gap = fr_gap.pop_front();
            repeat (l) got_q.push_back(fr_bytes.pop_front());
        end
    endtask

    task automatic cmp_frame(input string tag, input int exp_er);
        int bad = -1;
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        chk({tag, "_first_bad_byte"}, 32'(bad), 32'hFFFF_FFFF);
        chk({tag, "_tx_er_cycles"}, 32'(got_er), 32'(exp_er));
    endtask

    initial begin
        int unsigned c;
        int uf0, n;
        for (int i = 0; i < 256; i++) begin
            c = i;
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        rst = 1'b1;
        #2;
        chk("rst_txd", 32'(gmii_txd), 32'h00);
        chk("rst_tx_en", 32'(gmii_tx_en), 32'd0);
        chk("rst_tx_er", 32'(gmii_tx_er), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: "123456789"
        pay = {};
        for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
        send_range(0, 9, 1);
        get_frame("t1");
        build_exp();
        cmp_frame("t1", 0);
`ifndef ETH_TX_PAD_EN
        chk("t1_wire_len", 32'(got_q.size()), 32'd21);
        if (got_q.size() == 21)
            chk("t1_fcs", {got_q[20], got_q[19], got_q[18], got_q[17]}, 32'hCBF43926);
`endif

        // 2: single byte 0xAB
        pay = {8'hAB};
        repeat (20) @(posedge clk); #1;
        send_range(0, 1, 1);
        get_frame("t2");
        build_exp();
        cmp_frame("t2", 0);
`ifdef ETH_TX_PAD_EN
        chk("t2_wire_len", 32'(got_q.size()), 32'd72);
`else
        chk("t2_wire_len", 32'(got_q.size()), 32'd13);
`endif

        // 3: back-to-back 64-byte frames, valid held high
        repeat (20) @(posedge clk); #1;
        rand_pay(64);
        send_range(0, 64, 0);
        build_exp();
        rand_pay(64);
        send_range(0, 64, 1);
        chk("t3_ready_low_gap_waits", 32'(first_wait), 32'd24);
        get_frame("t3a");
        cmp_frame("t3a", 0);
        build_exp();
        get_frame("t3b");
        cmp_frame("t3b", 0);
        chk("t3_ifg", 32'(got_gap), 32'(IFG));

        // 4: underflow after 10 bytes
        repeat (20) @(posedge clk); #1;
        uf0 = uf_cnt;
        rand_pay(20);
        send_range(0, 10, 0);
        s_valid = 1'b0;
        @(posedge clk); #1;
        send_range(10, 20, 1);
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        chk("t4_ifg_to_idle", 32'(n), 32'(IFG));
        repeat (3) @(posedge clk); #1;
        chk("t4_single_burst", 32'(fr_len.size()), 32'd1);
        chk("t4_underflow_pulses", 32'(uf_cnt - uf0), 32'd1);
        exp_q = {};
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 10; i++) exp_q.push_back(pay[i]);
        exp_q.push_back(8'h00);
        get_frame("t4");
        cmp_frame("t4", 1);

        // 5: async reset mid-DATA
        repeat (10) @(posedge clk); #1;
        rand_pay(100);
        send_range(0, 20, 0);
        chk("t5_in_frame", 32'(gmii_tx_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_tx_en", 32'(gmii_tx_en), 32'd0);
        chk("t5_tx_er", 32'(gmii_tx_er), 32'd0);
        chk("t5_txd", 32'(gmii_txd), 32'h00);
        chk("t5_busy", 32'(busy), 32'd0);
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        get_frame("t5_trunc");
        repeat (5) @(posedge clk); #1;
        rand_pay(100);
        send_range(0, 100, 1);
        get_frame("t5");
        build_exp();
        cmp_frame("t5", 0);

        // random lengths
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            @(posedge clk); #1;
            rand_pay($urandom_range(1, 120));
            send_range(0, pay.size(), 1);
            get_frame("rnd");
            build_exp();
            cmp_frame("rnd", 0);
        end

        // 6: 1500-byte frame after 50 idle cycles
        repeat (50) @(posedge clk); #1;
        rand_pay(1500);
        n = cyc;
        stall = 0;
        send_range(0, 1500, 1);
        chk("t6_first_accept_wait", 32'(first_wait), 32'd9);
        chk("t6_stalls", 32'(stall), 32'd0);
        get_frame("t6");
        chk("t6_preamble_latency", 32'(first_en_cyc - n), 32'd2);
        build_exp();
        cmp_frame("t6", 0);

        chk("tx_er_outside_frame", 32'(er_outside), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_tx_mac.md
Name: eth_tx_mac

Overview:
GMII-side Ethernet transmit framer sitting directly upstream of gmii_to_rgmii in the MAC clock domain.
- Accepts a payload byte stream over a valid/ready/last handshake.
- Wraps each frame with preamble, SFD, optional minimum-length padding and CRC-32 FCS.
- Enforces the inter-frame gap and drives byte-wide GMII transmit signals for the RGMII converter.

Parameters:
- IFG_BYTES, 12, minimum number of cycles with gmii_tx_en low between frames (at least 1)
- MIN_FRAME, 60, minimum payload-plus-pad byte count before FCS (used only with padding)

Ports:
- clk  in  1  MAC byte clock (125 MHz from pll)
- rst  in  1  asynchronous, active-high reset (driven from mac_rst)
- s_data  in  8  payload byte
- s_valid  in  1  s_data/s_last valid
- s_last  in  1  current byte is the last payload byte of the frame
- s_ready  out  1  block accepts the byte this cycle
- gmii_txd  out  8  transmit byte to gmii_to_rgmii
- gmii_tx_en  out  1  transmit enable
- gmii_tx_er  out  1  transmit error
- busy  out  1  state is not IDLE
- underflow  out  1  one-cycle pulse when a frame is aborted by input starvation

Behaviour:
- Reset (async, asserted): state=IDLE; gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, underflow=0; CRC=0xFFFFFFFF; all counters 0. A frame in flight is truncated on the wire.
- gmii_* and underflow are registered. Byte for state S in cycle t appears on the GMII outputs in cycle t+1.
- s_ready is combinational: high only in DATA and DRAIN. A transfer is s_valid && s_ready.

States:
- IDLE: outputs tx_en=0. s_valid=1 moves to PREAMBLE; no byte is consumed.
- PREAMBLE: 7 cycles of 0x55, tx_en=1. CRC is initialised to 0xFFFFFFFF. Then SFD.
- SFD: 1 cycle of 0xD5. Then DATA.
- DATA: on each transfer, emit s_data, update CRC, and increment the 16-bit byte count (saturating at 0xFFFF).
  - Transfer with s_last: go to PAD if count+1 < MIN_FRAME and padding is compiled in; otherwise go to FCS.
  - s_valid=0 (underflow): emit 0x00 with tx_en=1, tx_er=1 for one cycle, pulse underflow, go to DRAIN.
- PAD: emit 0x00 and update CRC until the byte count reaches MIN_FRAME. Then FCS.
- FCS: 4 cycles emitting ~CRC, least-significant byte first. Then IFG.
- DRAIN: tx_en=0, s_ready=1. Discard input until a transfer with s_last, then IFG. A transfer with s_last on the first DRAIN cycle is accepted normally.
- IFG: tx_en=0 for IFG_BYTES cycles. On the final cycle, go to PREAMBLE if s_valid=1, else IDLE. Back-to-back frames therefore have exactly IFG_BYTES idle cycles between them.

CRC and other rules:
- CRC: reflected IEEE 802.3 CRC-32, polynomial 0xEDB88320, LSB-first per byte, computed combinationally one byte per cycle. Covers payload and pad; excludes preamble, SFD and FCS.
- gmii_tx_er=0 in every cycle except the underflow cycle.
- Counts:
  - Frame length on the wire (tx_en high) = 8 + max(N, MIN_FRAME) + 4 cycles with padding, or 8 + N + 4 without.
  - A zero-length frame is impossible: the first accepted byte is always payload.
- s_data is ignored in IDLE, PREAMBLE, SFD, PAD, FCS and IFG; no transfers occur in those states.

Optional Feature:
- Macro ETH_TX_PAD_EN.
- Defined: frames whose payload is shorter than MIN_FRAME enter PAD and are zero-padded up to MIN_FRAME bytes; CRC covers the pad.
- Undefined: the PAD state and its counter compare are not built. DATA with s_last always goes straight to FCS, and short frames are sent unpadded.

Test Plan:
1. ETH_TX_PAD_EN undefined; payload ASCII "123456789" (0x31..0x39) with s_last on 0x39 -> tx_en high 21 cycles: 55×7, D5, 31..39, then FCS 26 39 F4 CB; tx_er always 0.
2. ETH_TX_PAD_EN defined; 1-byte payload 0xAB -> tx_en high 72 cycles: preamble, SFD, AB, 59×0x00, then 4 FCS bytes matching the bench CRC model.
3. Two back-to-back 64-byte frames with s_valid held high -> exactly 12 cycles of tx_en=0 between the last FCS byte of frame 1 and the first 0x55 of frame 2; s_ready low throughout the gap.
4. Drop s_valid for one cycle after 10 payload bytes -> the next GMII cycle is txd=00, tx_en=1, tx_er=1 with underflow pulsing once. Then tx_en=0 while the remaining bytes up to s_last are drained, followed by 12 IFG cycles, then IDLE.
5. Assert rst mid-DATA (byte 20 of 100) -> gmii_tx_en, gmii_tx_er, gmii_txd and busy go to 0 without waiting for a clock edge. After release, a new frame starts cleanly with a correct FCS.
6. Hold s_valid low in IDLE for 50 cycles, then present 1500-byte frame -> first 0x55 appears 2 cycles after s_valid rises. All 1500 bytes are transferred with no stall, and FCS matches the model.
